// File: rtl/shared_mul_sched.sv
// shared_mul_sched: two requesters share one 32x32 signed shift-add multiplier,
// granted round-robin. Define ZERO_BYPASS_EN to short-cut zero-operand requests.
module shared_mul_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] m_r;
  logic [31:0] q_r;
  logic [32:0] acc_r;
  logic        sign_r;
  logic        id_r;
  logic        last_r;
  logic        busy_r;
  logic [5:0]  cnt_r;
  logic        rsp_valid_r;
  logic        rsp_id_r;
  logic [63:0] rsp_result_r;

  logic        win_s;
  logic        grant0_s;
  logic        grant1_s;
  logic        fire_s;
  logic [31:0] sel_a_s;
  logic [31:0] sel_b_s;
  logic [32:0] sum_s;
  logic [63:0] prod_s;
  logic [63:0] neg_s;

  // |v| as unsigned; -2^31 maps to 0x8000_0000 without overflow
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  // Round-robin winner: on contention the side not granted last wins
  always_comb begin
    win_s = 1'b0;
    if (req0_valid && req1_valid) begin
      win_s = ~last_r;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
  end

  assign grant0_s   = (state_r == IDLE) && !rst && req0_valid && !win_s;
  assign grant1_s   = (state_r == IDLE) && !rst && req1_valid &&  win_s;
  assign fire_s     = grant0_s | grant1_s;
  assign sel_a_s    = win_s ? req1_a : req0_a;
  assign sel_b_s    = win_s ? req1_b : req0_b;
  assign sum_s      = q_r[0] ? (acc_r + {1'b0, m_r}) : acc_r;
  assign prod_s     = {acc_r[31:0], q_r};
  assign neg_s      = ~prod_s + 64'd1;

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign busy       = busy_r;

  // Scheduler FSM, multiplier datapath and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      m_r          <= 32'd0;
      q_r          <= 32'd0;
      acc_r        <= 33'd0;
      sign_r       <= 1'b0;
      id_r         <= 1'b0;
      last_r       <= 1'b1;
      busy_r       <= 1'b0;
      cnt_r        <= 6'd0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= 64'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fire_s) begin
            last_r <= grant1_s;
            m_r    <= mag32(sel_a_s);
            q_r    <= mag32(sel_b_s);
            acc_r  <= 33'd0;
            sign_r <= sel_a_s[31] ^ sel_b_s[31];
            id_r   <= grant1_s;
            cnt_r  <= 6'd0;
            busy_r <= 1'b1;
`ifdef ZERO_BYPASS_EN
            if ((sel_a_s == 32'd0) || (sel_b_s == 32'd0)) begin
              state_r      <= DONE;
              rsp_valid_r  <= 1'b1;
              rsp_id_r     <= grant1_s;
              rsp_result_r <= 64'd0;
            end else begin
              state_r <= CALC;
            end
`else
            state_r <= CALC;
`endif
          end
        end
        CALC: begin
          // cnt_r == 32 means all steps are done; this edge publishes the result
          if (cnt_r == 6'd32) begin
            state_r      <= DONE;
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= id_r;
            rsp_result_r <= sign_r ? neg_s : prod_s;
          end else begin
            acc_r <= {1'b0, sum_s[32:1]};
            q_r   <= {sum_s[0], q_r[31:1]};
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= 64'd0;
          end
        end
        default: begin
          state_r      <= IDLE;
          busy_r       <= 1'b0;
          cnt_r        <= 6'd0;
          rsp_valid_r  <= 1'b0;
          rsp_id_r     <= 1'b0;
          rsp_result_r <= 64'd0;
        end
      endcase
    end
  end

endmodule
